// File: rtl/seq_gen_10010_tx.sv
// seq_gen_10010_tx
// Serial transmitter that sends bursts of a 5-bit pattern, MSB first, on a
// one-bit line. Frames in a burst are separated by a programmable number of
// idle-zero bits. All outputs are decoded from registered state only, so no
// input reaches an output without passing through a flop.

module seq_gen_10010_tx #(
  parameter logic [4:0] PATTERN = 5'b10010,
  parameter int         FRAME_W = 8,
  parameter int         GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic [GAP_W-1:0]   gap,
  input  logic               abort,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Bit index of the first (most significant) pattern bit of a frame
  localparam logic [2:0] BIT_FIRST = 3'd4;
  localparam logic [2:0] BIT_LAST  = 3'd0;

  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);
  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);

  logic [1:0]         state_q, state_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0] frames_left_q, frames_left_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // Status decodes used by the next-state logic
  logic frame_end;
  logic last_frame;
  logic gap_last;

  assign frame_end  = (bit_idx_q == BIT_LAST);
  assign last_frame = (frames_left_q == FRAME_ONE);
  assign gap_last   = (gap_cnt_q == GAP_ONE);

  // Next-state and counter update logic for the burst controller
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    frames_left_d = frames_left_q;
    gap_len_d     = gap_len_q;
    gap_cnt_d     = gap_cnt_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_cnt_d = '0;
          if (num_frames != '0) begin
            frames_left_d = num_frames;
            gap_len_d     = gap;
            bit_idx_d     = BIT_FIRST;
            state_d       = ST_SEND;
          end else begin
            // Empty burst: report completion without touching the line
            state_d = ST_DONE;
          end
        end
      end

      ST_SEND: begin
        // The last bit of a frame is fully on the line during this cycle,
        // so the frame counts as completed even if abort arrives with it.
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + FRAME_ONE;
          bit_idx_d   = BIT_FIRST;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
        end

        if (abort) begin
          state_d = ST_DONE;
        end else if (frame_end) begin
          if (last_frame) begin
            state_d = ST_DONE;
          end else begin
            frames_left_d = frames_left_q - FRAME_ONE;
            if (gap_len_q == '0) begin
              state_d = ST_SEND;
            end else begin
              gap_cnt_d = gap_len_q;
              state_d   = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (gap_last) begin
          gap_cnt_d = '0;
          bit_idx_d = BIT_FIRST;
          state_d   = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      ST_DONE: begin
        // Leave the working counters clean for the next burst
        bit_idx_d     = '0;
        gap_cnt_d     = '0;
        frames_left_d = '0;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      frames_left_q <= '0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      frames_left_q <= frames_left_d;
      gap_len_q     <= gap_len_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Pattern bit selected by the registered bit index
  logic pattern_bit;

  always_comb begin
    pattern_bit = 1'b0;
    case (bit_idx_q)
      3'd4:    pattern_bit = PATTERN[4];
      3'd3:    pattern_bit = PATTERN[3];
      3'd2:    pattern_bit = PATTERN[2];
      3'd1:    pattern_bit = PATTERN[1];
      3'd0:    pattern_bit = PATTERN[0];
      default: pattern_bit = 1'b0;
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    out       = (state_q == ST_SEND) && pattern_bit;
    out_valid = (state_q == ST_SEND) || (state_q == ST_GAP);
    busy      = (state_q == ST_SEND) || (state_q == ST_GAP);
    done      = (state_q == ST_DONE);
  end

  assign frame_cnt = frame_cnt_q;

endmodule
